// File: rtl/wb_stage_p_pkg.sv
// Shared encodings for the writeback stage: writeback source select and
// load access size.
package wb_stage_p_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2,
    WB_SRC_RSVD = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    LD_BYTE = 2'd0,
    LD_HALF = 2'd1,
    LD_WORD = 2'd2
  } ld_size_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load-data extension: selects the little-endian byte or
// halfword lane addressed by the low address bits and sign- or zero-extends
// it to the full data width. Word and the unused size code pass through.
module wb_load_ext
  import wb_stage_p_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_signed_i,
  input  logic [1:0]        ld_offset_i,
  output logic [DATA_W-1:0] ext_data_o
);

  logic [DATA_W-1:0] w_byte_sh;
  logic [DATA_W-1:0] w_half_sh;

  // Lane selection by shift; a half access ignores offset bit 0.
  assign w_byte_sh = mem_data_i >> {ld_offset_i, 3'b000};
  assign w_half_sh = mem_data_i >> {ld_offset_i[1], 4'b0000};

  // Extend the selected lane according to size and signedness.
  always_comb begin
    ext_data_o = mem_data_i;
    case (ld_size_e'(ld_size_i))
      LD_BYTE: begin
        if (ld_signed_i)
          ext_data_o = {{(DATA_W-8){w_byte_sh[7]}}, w_byte_sh[7:0]};
        else
          ext_data_o = {{(DATA_W-8){1'b0}}, w_byte_sh[7:0]};
      end
      LD_HALF: begin
        if (ld_signed_i)
          ext_data_o = {{(DATA_W-16){w_half_sh[15]}}, w_half_sh[15:0]};
        else
          ext_data_o = {{(DATA_W-16){1'b0}}, w_half_sh[15:0]};
      end
      default: ext_data_o = mem_data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// Pipeline writeback stage: registers the incoming instruction, selects the
// writeback data, suppresses writes to register 0, keeps a one-cycle-old copy
// of the writeback for forwarding and counts retired instructions.
// Optional feature macro: WB_LOAD_EXT_EN (sub-word load extension). Without
// it, MEM-source data is the raw registered load word and ld_* are ignored.
// There is no handshake: valid_i qualifies the inputs on every non-stalled
// edge, stall_i freezes the whole stage, flush_i kills the incoming one.
module wb_stage_p
  import wb_stage_p_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_W-1:0]     aluData_i,
  input  logic [DATA_W-1:0]     memData_i,
  input  logic [DATA_W-1:0]     linkData_i,
  input  logic [1:0]            c_WBSrc_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic                  c_RegWrite_i,
  input  logic [1:0]            ld_size_i,
  input  logic                  ld_signed_i,
  input  logic [1:0]            ld_offset_i,
  output logic [DATA_W-1:0]     e_WBData,
  output logic                  e_RegWrite,
  output logic [REG_ADDR_W-1:0] e_WBAddr,
  output logic                  e_Valid,
  output logic [DATA_W-1:0]     e_PrevWBData,
  output logic [REG_ADDR_W-1:0] e_PrevWBAddr,
  output logic                  e_PrevRegWrite,
  output logic [RETIRE_W-1:0]   e_RetireCnt
);

  logic                  r_valid;
  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_addr;
  wb_src_e               r_src;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_mem;
  logic [DATA_W-1:0]     r_link;
  logic [DATA_W-1:0]     r_prev_data;
  logic [REG_ADDR_W-1:0] r_prev_addr;
  logic                  r_prev_we;
  logic [RETIRE_W-1:0]   r_retire;

  logic [DATA_W-1:0]     w_mem_data;
  logic [DATA_W-1:0]     w_wb_data;
  logic                  w_regwrite;

`ifdef WB_LOAD_EXT_EN
  logic [1:0]            r_ld_size;
  logic                  r_ld_signed;
  logic [1:0]            r_ld_offset;

  // Load-shape registers exist only when extension is compiled in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_size   <= 2'd0;
      r_ld_signed <= 1'b0;
      r_ld_offset <= 2'd0;
    end else if (!stall_i) begin
      r_ld_size   <= ld_size_i;
      r_ld_signed <= ld_signed_i;
      r_ld_offset <= ld_offset_i;
    end
  end

  wb_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .mem_data_i  (r_mem),
    .ld_size_i   (r_ld_size),
    .ld_signed_i (r_ld_signed),
    .ld_offset_i (r_ld_offset),
    .ext_data_o  (w_mem_data)
  );
`else
  logic w_ld_unused;
  assign w_ld_unused = ^{ld_size_i, ld_signed_i, ld_offset_i};
  assign w_mem_data  = r_mem;
`endif

  // Stage capture: reset clears, stall holds, flush kills valid/write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_addr     <= '0;
      r_src      <= WB_SRC_ALU;
      r_alu      <= '0;
      r_mem      <= '0;
      r_link     <= '0;
    end else if (!stall_i) begin
      r_valid    <= valid_i & ~flush_i;
      r_regwrite <= c_RegWrite_i & ~flush_i;
      r_addr     <= wb_addr_i;
      r_src      <= wb_src_e'(c_WBSrc_i);
      r_alu      <= aluData_i;
      r_mem      <= memData_i;
      r_link     <= linkData_i;
    end
  end

  // Writeback data select; the reserved code falls back to the ALU result.
  always_comb begin
    w_wb_data = r_alu;
    case (r_src)
      WB_SRC_MEM:  w_wb_data = w_mem_data;
      WB_SRC_LINK: w_wb_data = r_link;
      default:     w_wb_data = r_alu;
    endcase
  end

  assign w_regwrite = r_valid & r_regwrite & (r_addr != '0);

  // One-cycle-old writeback copy for forwarding into younger instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_data <= '0;
      r_prev_addr <= '0;
      r_prev_we   <= 1'b0;
    end else if (!stall_i) begin
      r_prev_data <= w_wb_data;
      r_prev_addr <= r_addr;
      r_prev_we   <= w_regwrite;
    end
  end

  // Retire counter: counts the instruction leaving the stage; wraps freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire <= '0;
    end else if (!stall_i && r_valid) begin
      r_retire <= r_retire + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  assign e_WBData       = w_wb_data;
  assign e_RegWrite     = w_regwrite;
  assign e_WBAddr       = r_addr;
  assign e_Valid        = r_valid;
  assign e_PrevWBData   = r_prev_data;
  assign e_PrevWBAddr   = r_prev_addr;
  assign e_PrevRegWrite = r_prev_we;
  assign e_RetireCnt    = r_retire;

endmodule
